tdm_demux_1x4: RTL and testbench

Sequential 1-to-4 time-division demultiplexer, the receive-side counterpart of the 4x1 select mux. It accepts a serial stream of samples, one per lane, in lane order 0,1,2,3. It assembles each group of four into a frame and presents the frame on a parallel output with a valid/ready handshake. It sits downstream of the mux path and restores the four parallel channels the mux serialised.

---
 rtl/tdm_pkg.sv | 23 ++
 rtl/tdm_out_reg.sv | 55 +++++
 rtl/tdm_demux_1x4.sv | 145 ++++++++++++++
 tb/tb_tdm_demux_1x4.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM mux/demux path.
//   TDM_LANES    : number of time-division lanes (fixed at 4)
//   TDM_LANE_W   : width of a lane index
//   lane_idx_t   : plain lane index
//   fill_state_t : lane currently being filled (FILL0..FILL3)
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int TDM_LANES  = 4;
    localparam int TDM_LANE_W = 2;

    typedef logic [TDM_LANE_W-1:0] lane_idx_t;

    typedef enum logic [TDM_LANE_W-1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FILL3 = 2'd3
    } fill_state_t;

endpackage : tdm_pkg

// File: rtl/tdm_out_reg.sv
// -----------------------------------------------------------------------------
// tdm_out_reg
// Holding register with a valid/ready output handshake. A load takes priority
// over a transfer, so a load on the same edge as a transfer keeps valid high
// with the new word. The caller only loads when the register is empty or is
// being drained on that edge.
// Ports:
//   clk_i    : rising-edge clock
//   rst_n_i  : synchronous active-low reset
//   load_i   : capture data_i this edge
//   data_i   : word to capture (WIDTH bits)
//   ready_i  : downstream accepts the held word
//   valid_o  : held word is valid
//   data_o   : held word
// -----------------------------------------------------------------------------
module tdm_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : tdm_out_reg

// File: rtl/tdm_demux_1x4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1x4
// Receive-side 1-to-4 time-division demultiplexer. Serial samples arrive in
// lane order 0..3; each group of four is assembled and presented as one
// parallel frame (lane 0 in the LSBs) through a valid/ready output register.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_data   : serial sample (W bits)
//   in_valid  : in_data valid this cycle
//   in_sof    : start of frame, marks the lane-0 sample
//   in_ready  : a sample can be accepted this cycle
//   out_data  : assembled frame (4*W bits)
//   out_valid : out_data holds a complete frame
//   out_ready : downstream accepts the frame
//   lane      : next lane to be written
//   err       : one-cycle pulse on frame misalignment
// Build option:
//   TDM_DEMUX_SOF_CHECK_EN : when defined, in_sof re-aligns the lane counter
//   and misalignment is flagged on err. When undefined, in_sof is ignored,
//   err is 0 and lanes are filled purely by count.
// -----------------------------------------------------------------------------
module tdm_demux_1x4
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic                   in_ready,
    output logic [TDM_LANES*W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TDM_LANE_W-1:0]  lane,
    output logic                   err
);

    // Slots 0..2 are buffered; the lane-3 sample goes straight into the
    // output register together with them.
    localparam int BUF_SLOTS = TDM_LANES - 1;

    fill_state_t  lane_q, lane_d;
    fill_state_t  wr_lane;
    logic [W-1:0] buf_q [BUF_SLOTS];
    logic [W-1:0] buf_d [BUF_SLOTS];
    logic [BUF_SLOTS-1:0] slot_we;
    logic         accept;
    logic         frame_done;
    logic         out_valid_w;
    logic [TDM_LANES*W-1:0] frame_w;

    // Stall only when finishing a frame would overwrite an undelivered one.
    assign in_ready = !(lane_q == FILL3 && out_valid_w && !out_ready);
    assign accept   = in_valid && in_ready;

`ifdef TDM_DEMUX_SOF_CHECK_EN
    logic err_q, err_d;
`else
    logic unused_sof;
    assign unused_sof = in_sof;
`endif

    always_comb begin
        wr_lane = lane_q;
`ifdef TDM_DEMUX_SOF_CHECK_EN
        err_d = 1'b0;
        // A start-of-frame away from lane 0 drops the partial frame and
        // restarts filling at slot 0 with this sample.
        if (in_sof && lane_q != FILL0) begin
            wr_lane = FILL0;
        end
        if (accept) begin
            err_d = (in_sof && lane_q != FILL0) || (!in_sof && lane_q == FILL0);
        end
`endif

        // 2-to-4 lane decode; lane 3 has no buffer slot.
        slot_we = '0;
        if (accept) begin
            case (wr_lane)
                FILL0:   slot_we[0] = 1'b1;
                FILL1:   slot_we[1] = 1'b1;
                FILL2:   slot_we[2] = 1'b1;
                default: slot_we    = '0;
            endcase
        end

        for (int i = 0; i < BUF_SLOTS; i++) begin
            buf_d[i] = slot_we[i] ? in_data : buf_q[i];
        end

        lane_d = lane_q;
        if (accept) begin
            lane_d = fill_state_t'(lane_idx_t'(wr_lane) + lane_idx_t'(1));
        end
    end

    assign frame_done = accept && (wr_lane == FILL3);
    assign frame_w    = {in_data, buf_q[2], buf_q[1], buf_q[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= FILL0;
            for (int i = 0; i < BUF_SLOTS; i++) begin
                buf_q[i] <= '0;
            end
`ifdef TDM_DEMUX_SOF_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            lane_q <= lane_d;
            for (int i = 0; i < BUF_SLOTS; i++) begin
                buf_q[i] <= buf_d[i];
            end
`ifdef TDM_DEMUX_SOF_CHECK_EN
            err_q <= err_d;
`endif
        end
    end

    tdm_out_reg #(
        .WIDTH (TDM_LANES * W)
    ) u_out_reg (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .load_i  (frame_done),
        .data_i  (frame_w),
        .ready_i (out_ready),
        .valid_o (out_valid_w),
        .data_o  (out_data)
    );

    assign out_valid = out_valid_w;
    assign lane      = lane_q;

`ifdef TDM_DEMUX_SOF_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule : tdm_demux_1x4

// File: tb/tb_tdm_demux_1x4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1x4
// Directed bench for tdm_demux_1x4 (W = 8). Inputs change 1 time unit after
// the rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1x4;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [4*W-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    lane;
    logic          err;

    int n_total;
    int n_pass;

    tdm_demux_1x4 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane      (lane),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for exactly one edge, then drop in_valid.
    task automatic send(input logic [W-1:0] d, input logic sof);
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        // 1. Reset for three cycles
        tick(); tick(); tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_lane",      lane,      2'd0);
        chk("rst_out_data",  out_data,  32'h0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_err",       err,       1'b0);

        // 2. One frame with downstream always ready
        send(8'h11, 1'b1);
        chk("f1_lane1", lane, 2'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("f1_lane3", lane, 2'd3);
        send(8'h44, 1'b0);
        chk("f1_valid", out_valid, 1'b1);
        chk("f1_data",  out_data,  32'h44332211);
        chk("f1_lane0", lane,      2'd0);
        tick();
        chk("f1_drop",  out_valid, 1'b0);

        // 3. Back-to-back frames with a stalled output
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        out_ready = 1'b0;
        chk("f2_valid", out_valid, 1'b1);
        chk("f2_data",  out_data,  32'h04030201);
        send(8'h05, 1'b1);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        chk("stall_lane",     lane,     2'd3);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_hold",     out_data, 32'h04030201);
        in_data  = 8'h08;
        in_valid = 1'b1;
        tick();
        chk("stall_lane_kept", lane,      2'd3);
        chk("stall_hold2",     out_data,  32'h04030201);
        chk("stall_valid",     out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("f3_valid", out_valid, 1'b1);
        chk("f3_data",  out_data,  32'h08070605);
        chk("f3_lane0", lane,      2'd0);
        tick();
        chk("f3_drop",  out_valid, 1'b0);

        // 4. Gapped input: idle cycles carry junk data that must be ignored
        send(8'hA1, 1'b1);
        in_data = 8'hEE;
        tick();
        chk("gap_lane1", lane, 2'd1);
        send(8'hA2, 1'b0);
        in_data = 8'hEE;
        tick();
        chk("gap_lane2", lane, 2'd2);
        send(8'hA3, 1'b0);
        in_data = 8'hEE;
        tick();
        chk("gap_lane3", lane, 2'd3);
        chk("gap_novalid", out_valid, 1'b0);
        send(8'hA4, 1'b0);
        chk("gap_valid", out_valid, 1'b1);
        chk("gap_data",  out_data,  32'hA4A3A2A1);
        tick();

        // 5. Reset in the middle of a frame
        send(8'h55, 1'b1);
        send(8'h66, 1'b0);
        chk("mid_lane2", lane, 2'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_lane",  lane,      2'd0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data",  out_data,  32'h0);
        send(8'hB1, 1'b1);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        chk("mid_novalid", out_valid, 1'b0);
        send(8'hB4, 1'b0);
        chk("mid_valid", out_valid, 1'b1);
        chk("mid_data",  out_data,  32'hB4B3B2B1);
        tick();

        // 6. Start-of-frame in the wrong place
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
`ifdef TDM_DEMUX_SOF_CHECK_EN
        send(8'h99, 1'b1);
        chk("sof_err",  err,  1'b1);
        chk("sof_lane", lane, 2'd1);
        tick();
        chk("sof_err_clear", err, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        chk("sof_valid", out_valid, 1'b1);
        chk("sof_data",  out_data,  32'hCCBBAA99);
        tick();
        send(8'h77, 1'b0);
        chk("nosof_err",  err,  1'b1);
        chk("nosof_lane", lane, 2'd1);
`else
        send(8'h99, 1'b1);
        chk("sof_ignored_err",  err,  1'b0);
        chk("sof_ignored_lane", lane, 2'd3);
        send(8'h44, 1'b0);
        chk("sof_ignored_valid", out_valid, 1'b1);
        chk("sof_ignored_data",  out_data,  32'h44992211);
        tick();
        chk("sof_ignored_err2", err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_tdm_demux_1x4
